// File: rtl/imem_access_ctrl_if.sv
// Fetch, loader and memory-array signals of the instruction memory controller.
// slave = controller view, master = environment (fetch stage, loader, array) view.
interface imem_access_ctrl_if;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_gnt;
  logic        fetch_rvalid;
  logic [31:0] fetch_rdata;
  logic        fetch_err;
  logic        load_req;
  logic        load_valid;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        load_ready;
  logic        load_err;
  logic [10:0] load_count;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  modport slave (
    input  fetch_req, fetch_addr, load_req, load_valid, load_addr, load_data, mem_rdata,
    output fetch_gnt, fetch_rvalid, fetch_rdata, fetch_err, load_ready, load_err,
           load_count, mem_addr, mem_we, mem_wdata, busy
  );

  modport master (
    output fetch_req, fetch_addr, load_req, load_valid, load_addr, load_data, mem_rdata,
    input  fetch_gnt, fetch_rvalid, fetch_rdata, fetch_err, load_ready, load_err,
           load_count, mem_addr, mem_we, mem_wdata, busy
  );
endinterface

// File: rtl/imem_access_ctrl.sv
// Shares the single instruction-memory port between fetch (1-cycle registered response)
// and a loader that gets exclusive write access via BOOT/RUN/DRAIN/LOAD; loader wins ties.
module imem_access_ctrl #(
  parameter int          DEPTH    = 1024,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input logic               clk,
  input logic               reset_n,
  imem_access_ctrl_if.slave bus
);
  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_DRAIN, ST_LOAD} state_t;

  state_t      state_q, state_d;
  logic        rvalid_q, rvalid_d;
  logic        ferr_q, ferr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        lerr_q, lerr_d;
  logic [10:0] cnt_q, cnt_d;

  logic        gnt, ready, beat, fetch_ok, load_ok, we;
  logic [31:0] maddr, mwdata;

  assign fetch_ok = (bus.fetch_addr[1:0] == 2'b00) && (bus.fetch_addr < ADDR_LIMIT);
  assign load_ok  = (bus.load_addr[1:0] == 2'b00) && (bus.load_addr < ADDR_LIMIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_BOOT;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT:  state_d = bus.load_req ? ST_LOAD : ST_RUN;
      ST_RUN:   state_d = bus.load_req ? ST_DRAIN : ST_RUN;
      ST_DRAIN: state_d = ST_LOAD;
      ST_LOAD:  state_d = bus.load_req ? ST_LOAD : ST_RUN;
      default:  state_d = ST_BOOT;
    endcase
  end

  // Memory port mux: a fetch grant and a load beat are mutually exclusive by state.
  always_comb begin
    gnt    = (state_q == ST_RUN) && bus.fetch_req && !bus.load_req;
    ready  = (state_q == ST_LOAD);
    beat   = ready && bus.load_valid;
    we     = beat && load_ok;
    maddr  = 32'h0;
    mwdata = 32'h0;
    if (gnt) begin
      maddr = bus.fetch_addr;
    end else if (beat) begin
      maddr  = bus.load_addr;
      mwdata = bus.load_data;
    end
  end

  always_comb begin
    rvalid_d = gnt;
    ferr_d   = 1'b0;
    rdata_d  = rdata_q;
    if (gnt) begin
      ferr_d  = !fetch_ok;
      rdata_d = fetch_ok ? bus.mem_rdata : NOP_WORD;
    end
    lerr_d = beat && !load_ok;
    cnt_d  = cnt_q;
    if (state_d == ST_LOAD && state_q != ST_LOAD) begin
      cnt_d = 11'd0;
    end else if (beat && cnt_q != 11'h7FF) begin
      cnt_d = cnt_q + 11'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rvalid_q <= 1'b0;
      ferr_q   <= 1'b0;
      rdata_q  <= NOP_WORD;
      lerr_q   <= 1'b0;
      cnt_q    <= 11'd0;
    end else begin
      rvalid_q <= rvalid_d;
      ferr_q   <= ferr_d;
      rdata_q  <= rdata_d;
      lerr_q   <= lerr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.fetch_gnt    = gnt;
  assign bus.fetch_rvalid = rvalid_q;
  assign bus.fetch_rdata  = rdata_q;
  assign bus.fetch_err    = ferr_q;
  assign bus.load_ready   = ready;
  assign bus.load_err     = lerr_q;
  assign bus.load_count   = cnt_q;
  assign bus.mem_addr     = maddr;
  assign bus.mem_we       = we;
  assign bus.mem_wdata    = mwdata;
  assign bus.busy         = (state_q != ST_RUN);
endmodule

// File: tb/tb_imem_access_ctrl.sv
// Randomized bench for imem_access_ctrl against a cycle-level behavioural model
// that keeps its own image of the program memory.
module tb_imem_access_ctrl;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int P_BOOT = 0, P_RUN = 1, P_DRAIN = 2, P_LOAD = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  imem_access_ctrl_if bus();

  imem_access_ctrl #(.DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  // The instruction memory array the controller drives.
  logic [31:0] arr [DEPTH];
  always_comb bus.mem_rdata = arr[bus.mem_addr[11:2]];
  always @(posedge clk) if (bus.mem_we) arr[bus.mem_addr[11:2]] <= bus.mem_wdata;

  // Reference model state.
  logic [31:0] model_mem [DEPTH];
  int          ph;
  logic        e_rvalid, e_err, e_lerr;
  logic [31:0] e_rdata;
  int          e_cnt;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    ph = P_BOOT; e_rvalid = 0; e_err = 0; e_lerr = 0; e_rdata = NOP; e_cnt = 0;
  endtask

  function automatic logic addr_ok(input logic [31:0] a);
    return (a % 4 == 0) && (a < DEPTH * 4);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"},    32'(bus.fetch_gnt), 0);
    check({tag, "_rvalid"}, 32'(bus.fetch_rvalid), 0);
    check({tag, "_rdata"},  bus.fetch_rdata, NOP);
    check({tag, "_ferr"},   32'(bus.fetch_err), 0);
    check({tag, "_ready"},  32'(bus.load_ready), 0);
    check({tag, "_lerr"},   32'(bus.load_err), 0);
    check({tag, "_cnt"},    32'(bus.load_count), 0);
    check({tag, "_we"},     32'(bus.mem_we), 0);
    check({tag, "_maddr"},  bus.mem_addr, 0);
    check({tag, "_wdata"},  bus.mem_wdata, 0);
    check({tag, "_busy"},   32'(bus.busy), 1);
  endtask

  task automatic drive(input logic fr, input logic [31:0] fa, input logic lr,
                       input logic lv, input logic [31:0] la, input logic [31:0] ld);
    bus.fetch_req = fr; bus.fetch_addr = fa; bus.load_req = lr;
    bus.load_valid = lv; bus.load_addr = la; bus.load_data = ld;
  endtask

  // One clock cycle: drive at negedge, check every output, then advance the model.
  task automatic cyc(input logic fr, input logic [31:0] fa, input logic lr,
                     input logic lv, input logic [31:0] la, input logic [31:0] ld);
    logic gnt, rdy, beat, we;
    logic [31:0] maddr;
    int np;
    @(negedge clk);
    drive(fr, fa, lr, lv, la, ld);
    #1;
    gnt   = (ph == P_RUN) && fr && !lr;
    rdy   = (ph == P_LOAD);
    beat  = rdy && lv;
    we    = beat && addr_ok(la);
    maddr = gnt ? fa : (beat ? la : 32'h0);
    check("fetch_gnt",    32'(bus.fetch_gnt), 32'(gnt));
    check("load_ready",   32'(bus.load_ready), 32'(rdy));
    check("mem_we",       32'(bus.mem_we), 32'(we));
    check("mem_addr",     bus.mem_addr, maddr);
    if (we) check("mem_wdata", bus.mem_wdata, ld);
    check("busy",         32'(bus.busy), 32'(ph != P_RUN));
    check("fetch_rvalid", 32'(bus.fetch_rvalid), 32'(e_rvalid));
    check("fetch_rdata",  bus.fetch_rdata, e_rdata);
    check("fetch_err",    32'(bus.fetch_err), 32'(e_err));
    check("load_err",     32'(bus.load_err), 32'(e_lerr));
    check("load_count",   32'(bus.load_count), 32'(e_cnt));
    case (ph)
      P_BOOT:  np = lr ? P_LOAD : P_RUN;
      P_RUN:   np = lr ? P_DRAIN : P_RUN;
      P_DRAIN: np = P_LOAD;
      default: np = lr ? P_LOAD : P_RUN;
    endcase
    e_rvalid = gnt;
    e_err    = gnt && !addr_ok(fa);
    if (gnt) e_rdata = addr_ok(fa) ? model_mem[fa / 4] : NOP;
    e_lerr = beat && !addr_ok(la);
    if (np == P_LOAD && ph != P_LOAD) e_cnt = 0;
    else if (beat && e_cnt < 2047) e_cnt++;
    if (we) model_mem[la / 4] = ld;
    ph = np;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_addr();
    int k;
    k = $urandom_range(0, 9);
    if (k < 8) return 32'($urandom_range(0, DEPTH - 1)) * 4;
    if (k == 8) return (32'($urandom_range(0, DEPTH - 1)) * 4) | 32'($urandom_range(1, 3));
    return 32'(DEPTH * 4) + 32'($urandom_range(0, 65535));
  endfunction

  initial begin
    logic lr_r;
    for (int i = 0; i < DEPTH; i++) begin
      arr[i] = $urandom;
      model_mem[i] = arr[i];
    end
    model_reset();
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check_reset_outputs("rst0");
    release_reset();

    // BOOT for one cycle, then a fetch of word 2.
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 32'h8, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    // Error fetches: misaligned then out of range.
    cyc(1, 32'h2, 0, 0, 0, 0);
    cyc(1, 32'h1000, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    // Load request during streaming fetch, then a dropped out-of-range beat.
    for (int i = 0; i < 4; i++) cyc(1, 32'(i * 4), 0, 0, 0, 0);
    cyc(1, 32'h10, 1, 0, 0, 0);
    cyc(1, 32'h14, 1, 0, 0, 0);
    cyc(1, 32'h18, 1, 1, 32'h1004, 32'hDEAD_BEEF);
    check("bad_beat_cnt", 32'(bus.load_count), 0);
    cyc(0, 0, 1, 0, 0, 0);
    check("bad_beat_cnt1", 32'(bus.load_count), 1);

    // Reset while a write is on the port.
    @(negedge clk);
    drive(0, 0, 1, 1, 32'h40, 32'h1234_5678);
    #1;
    check("midload_we_before", 32'(bus.mem_we), 1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rst1");
    model_reset();
    drive(0, 0, 1, 0, 0, 0);
    repeat (2) @(negedge clk);
    release_reset();

    // Program then run, load_req held through reset release.
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 32'h0, 32'h0050_0093);
    cyc(0, 0, 1, 1, 32'h4, 32'h0010_0113);
    cyc(0, 0, 0, 0, 0, 0);
    check("prog_cnt", 32'(bus.load_count), 2);
    cyc(1, 32'h0, 0, 0, 0, 0);
    cyc(1, 32'h4, 0, 0, 0, 0);
    check("prog_w0", bus.fetch_rdata, 32'h0050_0093);
    cyc(0, 0, 0, 0, 0, 0);
    check("prog_w1", bus.fetch_rdata, 32'h0010_0113);

    // Randomized traffic.
    lr_r = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 19) == 0) lr_r = ~lr_r;
      cyc(($urandom_range(0, 9) < 7), rand_addr(), lr_r,
          lr_r && ($urandom_range(0, 1) == 1), rand_addr(), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
